// File: rtl/als_spi_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// als_spi_reader
//   SPI master front end for the PmodALS ambient-light sensor (ADC081S021).
//   Runs one 16-clock read-only frame per launch, extracts the 8-bit light
//   value and presents it with a one-cycle valid strobe.
//
// Ports
//   clk_pi      system clock (clock-wizard output)
//   rst_pi      asynchronous reset, active-high
//   start_pi    one-cycle request for a single conversion
//   auto_en_pi  1 = launch a frame every SAMPLE_PERIOD cycles
//   miso_pi     serial data from the ADC (changes on SCK falling edges)
//   cs_ctrl_po  chip select, active-low
//   sck_po      SPI clock, idles high
//   data_po     last light value (frame bits 12:5)
//   frame_po    last raw 16-bit frame, MSB first
//   valid_po    one-cycle pulse when data_po/frame_po update
//   busy_po     high from frame launch through the end of the quiet gap
// -----------------------------------------------------------------------------
module als_spi_reader #(
  parameter int unsigned SCK_HALF_DIV  = 5,
  parameter int unsigned QUIET_CYC     = 10,
  parameter int unsigned SAMPLE_PERIOD = 1_000_000
) (
  input  logic        clk_pi,
  input  logic        rst_pi,
  input  logic        start_pi,
  input  logic        auto_en_pi,
  input  logic        miso_pi,
  output logic        cs_ctrl_po,
  output logic        sck_po,
  output logic [7:0]  data_po,
  output logic [15:0] frame_po,
  output logic        valid_po,
  output logic        busy_po
);

  // One phase counter serves both the SCK half-periods and the quiet gap.
  localparam int unsigned CNT_MAX = (SCK_HALF_DIV > QUIET_CYC) ? SCK_HALF_DIV : QUIET_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned AUTO_W  = $clog2(SAMPLE_PERIOD + 1);

  localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(SCK_HALF_DIV - 1);
  localparam logic [CNT_W-1:0]  QUIET_LAST = CNT_W'(QUIET_CYC - 1);
  localparam logic [AUTO_W-1:0] AUTO_LOAD  = AUTO_W'(SAMPLE_PERIOD - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_QUIET
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         edge_q, edge_d;
  logic [15:0]        shift_q, shift_d;
  logic               pending_q, pending_d;
  logic [AUTO_W-1:0]  auto_q, auto_d;
  logic               cs_q, cs_d;
  logic               sck_q, sck_d;
  logic [7:0]         data_q, data_d;
  logic [15:0]        frame_q, frame_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  logic               auto_hit;
  logic               launch;

  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      edge_q    <= '0;
      shift_q   <= '0;
      pending_q <= 1'b0;
      auto_q    <= '0;
      cs_q      <= 1'b1;
      sck_q     <= 1'b1;
      data_q    <= '0;
      frame_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      shift_q   <= shift_d;
      pending_q <= pending_d;
      auto_q    <= auto_d;
      cs_q      <= cs_d;
      sck_q     <= sck_d;
      data_q    <= data_d;
      frame_q   <= frame_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    shift_d   = shift_q;
    pending_d = pending_q;
    auto_d    = auto_q;
    cs_d      = cs_q;
    sck_d     = sck_q;
    data_d    = data_q;
    frame_d   = frame_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;

    auto_hit = auto_en_pi && (auto_q == '0);
    launch   = (state_q == ST_IDLE) && (start_pi || pending_q || auto_hit);

    // Auto counter: disabled holds at zero; any launch restarts the period;
    // otherwise it counts down and parks at zero until consumed.
    if (!auto_en_pi) begin
      auto_d = '0;
    end else if (launch) begin
      auto_d = AUTO_LOAD;
    end else if (auto_q != '0) begin
      auto_d = auto_q - AUTO_W'(1);
    end

    // Requests arriving outside IDLE merge into a single pending flag.
    if ((state_q != ST_IDLE) && (start_pi || auto_hit)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d   = ST_SETUP;
          cs_d      = 1'b0;
          sck_d     = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = '0;
          pending_d = 1'b0;
        end
      end

      ST_SETUP: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          edge_d  = '0;
          sck_d   = 1'b0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SHIFT: begin
        // Even edge_q = SCK low half; its last cycle is the 0->1 edge, which
        // is where MISO is captured.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!edge_q[0]) begin
            shift_d = {shift_q[14:0], miso_pi};
          end
          if (edge_q == 5'd31) begin
            state_d = ST_HOLD;
          end else begin
            edge_d = edge_q + 5'd1;
            sck_d  = ~sck_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          valid_d = 1'b1;
          frame_d = shift_q;
          data_d  = shift_q[12:5];
          state_d = ST_QUIET;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_QUIET: begin
        if (cnt_q == QUIET_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b1;
        sck_d   = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign cs_ctrl_po = cs_q;
  assign sck_po     = sck_q;
  assign data_po    = data_q;
  assign frame_po   = frame_q;
  assign valid_po   = valid_q;
  assign busy_po    = busy_q;

endmodule

// File: tb/tb_als_spi_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_als_spi_reader
//   Self-checking bench for als_spi_reader. An ADC model serves 16-bit words
//   from a queue, one per CS falling edge, MSB first on SCK falling edges.
//   A cycle monitor measures CS/SCK timing and checks every valid_po pulse
//   against a scoreboard of expected words.
// -----------------------------------------------------------------------------
module tb_als_spi_reader;

  localparam int H = 5;
  localparam int Q = 10;
  localparam int P = 400;

  logic        clk_pi     = 1'b0;
  logic        rst_pi     = 1'b0;
  logic        start_pi   = 1'b0;
  logic        auto_en_pi = 1'b0;
  logic        miso_pi    = 1'b0;
  logic        cs_ctrl_po;
  logic        sck_po;
  logic [7:0]  data_po;
  logic [15:0] frame_po;
  logic        valid_po;
  logic        busy_po;

  int tests_run    = 0;
  int tests_failed = 0;

  als_spi_reader #(
    .SCK_HALF_DIV (H),
    .QUIET_CYC    (Q),
    .SAMPLE_PERIOD(P)
  ) dut (
    .clk_pi    (clk_pi),
    .rst_pi    (rst_pi),
    .start_pi  (start_pi),
    .auto_en_pi(auto_en_pi),
    .miso_pi   (miso_pi),
    .cs_ctrl_po(cs_ctrl_po),
    .sck_po    (sck_po),
    .data_po   (data_po),
    .frame_po  (frame_po),
    .valid_po  (valid_po),
    .busy_po   (busy_po)
  );

  always #5 clk_pi = ~clk_pi;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the light value is the 8 bits following the 3 leading zeros.
  function automatic logic [7:0] model_light(input logic [15:0] w);
    int v;
    v = int'(w);
    return 8'((v / 32) % 256);
  endfunction

  // ---------------- ADC model ----------------
  logic [15:0] adc_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] adc_word = 16'h0;
  int          adc_bit  = 0;

  always @(negedge cs_ctrl_po) begin
    adc_bit = 0;
    if (adc_q.size() > 0) adc_word = adc_q.pop_front();
    else                  adc_word = 16'h0;
  end

  always @(negedge sck_po) begin
    #1;
    if (cs_ctrl_po == 1'b0 && adc_bit < 16) begin
      miso_pi = adc_word[15 - adc_bit];
      adc_bit++;
    end
  end

  // ---------------- Cycle monitor ----------------
  int   cyc = 0, valid_cnt = 0, fall_cnt = 0, frame_no = 0;
  int   cs_low_run = 0, rise_run = 0, sfall_run = 0;
  int   last_rise_cyc = 0, last_fall_cyc = 0, gap_last = 0, spacing_last = 0;
  bit   aborted = 1'b0;
  logic cs_prev = 1'b1, sck_prev = 1'b1;

  always @(negedge clk_pi) begin
    logic [15:0] w;
    cyc++;
    if (rst_pi) aborted = 1'b1;
    if (cs_ctrl_po === 1'b0) begin
      cs_low_run++;
      if (sck_po === 1'b1 && sck_prev === 1'b0) rise_run++;
      if (sck_po === 1'b0 && sck_prev === 1'b1) sfall_run++;
    end
    if (cs_ctrl_po === 1'b0 && cs_prev === 1'b1) begin
      fall_cnt++;
      spacing_last  = cyc - last_fall_cyc;
      gap_last      = cyc - last_rise_cyc;
      last_fall_cyc = cyc;
      aborted       = 1'b0;
    end
    if (cs_ctrl_po === 1'b1 && cs_prev === 1'b0) begin
      last_rise_cyc = cyc;
      if (!aborted) begin
        check("cs_low_len", cs_low_run, 34 * H);
        check("sck_rises", rise_run, 16);
        check("sck_falls", sfall_run, 16);
      end
    end
    if (cs_ctrl_po !== 1'b0) begin
      cs_low_run = 0;
      rise_run   = 0;
      sfall_run  = 0;
    end
    if (valid_po === 1'b1) begin
      valid_cnt++;
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        frame_no++;
        $display("[TB] frame %0d: frame_po=0x%04h data_po=0x%02h expect 0x%04h/0x%02h",
                 frame_no, frame_po, data_po, w, model_light(w));
        check("frame_po", frame_po, w);
        check("data_po", data_po, model_light(w));
        check("cs_high_at_valid", cs_ctrl_po, 1'b1);
      end else begin
        check("spurious_valid", valid_po, 1'b0);
      end
    end
    cs_prev  = cs_ctrl_po;
    sck_prev = sck_po;
  end

  // ---------------- Stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk_pi);
    #1;
  endtask

  task automatic pulse_start();
    start_pi = 1'b1;
    tick(1);
    start_pi = 1'b0;
  endtask

  task automatic push_frame(input logic [15:0] w);
    adc_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_valids(input string tag, input int n, input int budget);
    int v0;
    int k;
    v0 = valid_cnt;
    k  = 0;
    while (valid_cnt < v0 + n && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, valid_cnt - v0, n);
  endtask

  initial begin
    int f0;
    int v0;
    int k;
    logic [15:0] w;

    // Reset then idle.
    #1 rst_pi = 1'b1;
    tick(3);
    rst_pi = 1'b0;
    tick(500);
    check("rst_cs", cs_ctrl_po, 1'b1);
    check("rst_sck", sck_po, 1'b1);
    check("rst_valid_cnt", valid_cnt, 0);
    check("rst_busy", busy_po, 1'b0);
    check("rst_data", data_po, 8'h00);
    check("rst_frame", frame_po, 16'h0000);
    check("rst_no_frames", fall_cnt, 0);

    // Directed frame 0x1AC0 -> light 0xD6.
    push_frame(16'h1AC0);
    pulse_start();
    wait_valids("valid_1ac0", 1, 400);
    check("busy_at_valid", busy_po, 1'b1);
    check("data_d6", data_po, 8'hD6);
    check("frame_1ac0", frame_po, 16'h1AC0);
    tick(1);
    check("valid_one_cycle", valid_po, 1'b0);
    tick(Q - 2);
    check("busy_end_quiet", busy_po, 1'b1);
    tick(1);
    check("busy_idle", busy_po, 1'b0);
    tick(20);

    // Full scale then zero; data_po holds while the next frame shifts.
    push_frame(16'h1FE0);
    pulse_start();
    wait_valids("valid_ff", 1, 400);
    check("data_ff", data_po, 8'hFF);
    tick(20);
    push_frame(16'h0000);
    pulse_start();
    tick(100);
    check("data_hold", data_po, 8'hFF);
    wait_valids("valid_00", 1, 400);
    check("data_00", data_po, 8'h00);
    tick(20);

    // Random words and random idle gaps.
    for (int i = 0; i < 12; i++) begin
      w = 16'($urandom);
      push_frame(w);
      tick($urandom_range(0, 30));
      pulse_start();
      wait_valids("valid_rand", 1, 400);
    end
    tick(30);

    // Three starts during SHIFT merge into exactly one extra frame.
    f0 = fall_cnt;
    push_frame(16'($urandom));
    push_frame(16'($urandom));
    pulse_start();
    k = 0;
    while (rise_run < 2 && k < 100) begin
      tick(1);
      k++;
    end
    check("shift_reached", (rise_run >= 2) ? 1 : 0, 1);
    for (int i = 0; i < 3; i++) begin
      pulse_start();
      tick(7);
    end
    wait_valids("valid_merge", 2, 800);
    check("relaunch_gap", gap_last, Q + 1);
    tick(400);
    check("merge_frames", fall_cnt - f0, 2);

    // Auto mode: launches every P cycles, stops when disabled.
    f0 = fall_cnt;
    for (int i = 0; i < 4; i++) push_frame(16'($urandom));
    auto_en_pi = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      k = 0;
      while (fall_cnt < f0 + i && k < 600) begin
        tick(1);
        k++;
      end
      check("auto_launch", fall_cnt - f0, i);
      if (i > 1) check("auto_spacing", spacing_last, P);
    end
    auto_en_pi = 1'b0;
    tick(1000);
    check("auto_stopped", fall_cnt - f0, 4);

    // Reset at the 9th SCK rising edge aborts the frame without valid.
    adc_q.push_back(16'h0AA0);
    v0 = valid_cnt;
    pulse_start();
    k = 0;
    while (rise_run < 9 && k < 400) begin
      tick(1);
      k++;
    end
    check("abort_point", rise_run, 9);
    rst_pi = 1'b1;
    #1;
    check("async_cs", cs_ctrl_po, 1'b1);
    check("async_sck", sck_po, 1'b1);
    check("async_busy", busy_po, 1'b0);
    tick(2);
    rst_pi = 1'b0;
    f0 = fall_cnt;
    tick(50);
    check("abort_no_valid", valid_cnt - v0, 0);
    check("abort_no_relaunch", fall_cnt - f0, 0);
    check("abort_data_cleared", data_po, 8'h00);
    push_frame(16'h15A0);
    pulse_start();
    wait_valids("valid_after_rst", 1, 400);
    check("data_after_rst", data_po, 8'hAD);
    tick(30);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
